// File: rtl/datapath_control_fsm.sv
// datapath_control_fsm: multi-cycle fetch/decode/execute controller that sits
// in front of the ALU fragment. It sequences FETCH -> DECODE -> EXEC -> {MEM}
// -> {WB} -> FETCH, drives the fragment selects and write strobes, and owns
// the memory read/write handshake including a per-access timeout.
// Optional feature: define CTRL_INTERRUPT_EN to add the one-cycle IRQ entry
// state. Without it, irq is ignored and r_backup/return_address_write stay 0.
module datapath_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [15:0] IRQ_VECTOR  = 16'h0010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  input  logic        zero_indicator,
  input  logic        should_skip,
  input  logic        irq,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_inc,
  output logic [2:0]  ALU_src_A,
  output logic [3:0]  ALU_src_B,
  output logic [3:0]  ALU_op,
  output logic        mem_shift,
  output logic [11:0] sign_12_to_16,
  output logic [11:0] zero_12_to_16,
  output logic        r_write,
  output logic        compare_write,
  output logic        return_address_write,
  output logic        r_backup,
  output logic        bus_error,
  output logic        illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IRQ
  } state_t;

  localparam logic [3:0] OP_ADDI  = 4'h0;
  localparam logic [3:0] OP_JUMPI = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_CMP   = 4'h4;
  localparam logic [3:0] OP_SKIP  = 4'h5;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d, done_state;
  logic [15:0] ir_q;
  logic [7:0]  cnt_q, cnt_d;
  // run_q is low for exactly one cycle after reset release or a timeout, so
  // the strobes are visibly low before a fresh access starts.
  logic        run_q, run_d;
  logic [3:0]  opcode;
  logic [2:0]  sel_a;
  logic [3:0]  sel_b, sel_op;

  // The vector itself is muxed inside the fragment (A select 7); the
  // controller only needs to pick that select.
  logic unused_sinks;
`ifdef CTRL_INTERRUPT_EN
  logic mask_q, mask_d;
  assign unused_sinks = ^{zero_indicator, IRQ_VECTOR};
`else
  assign unused_sinks = ^{zero_indicator, IRQ_VECTOR, irq};
`endif

  assign opcode        = ir_q[15:12];
  assign sign_12_to_16 = ir_q[11:0];
  assign zero_12_to_16 = ir_q[11:0];

  // State, instruction register and access-timeout registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      if (ir_write) ir_q <= instr_in;
    end
  end

`ifdef CTRL_INTERRUPT_EN
  // Interrupt mask: set on IRQ entry, cleared by the next completed fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask_q <= 1'b0;
    else          mask_q <= mask_d;
  end
`endif

  // Per-opcode ALU selects; held through EXEC, MEM and WB so address and
  // write-back result stay stable
  always_comb begin
    sel_a  = 3'd0;
    sel_b  = 4'd0;
    sel_op = 4'd0;
    case (opcode)
      OP_ADDI:           sel_b = 4'd5;
      OP_JUMPI: begin
        sel_a = 3'd4;
        sel_b = 4'd5;
      end
      OP_LOAD, OP_STORE: sel_b = 4'd4;
      OP_CMP: begin
        sel_b  = 4'd5;
        sel_op = 4'd1;
      end
      default: ;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d              = state_q;
    cnt_d                = '0;
    run_d                = 1'b1;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    pc_inc               = 2'd0;
    ALU_src_A            = 3'd0;
    ALU_src_B            = 4'd0;
    ALU_op               = 4'd0;
    mem_shift            = 1'b0;
    r_write              = 1'b0;
    compare_write        = 1'b0;
    return_address_write = 1'b0;
    r_backup             = 1'b0;
    bus_error            = 1'b0;
    illegal_op           = 1'b0;
`ifdef CTRL_INTERRUPT_EN
    mask_d     = mask_q;
    done_state = (irq && !mask_q) ? S_IRQ : S_FETCH;
`else
    done_state = S_FETCH;
`endif
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          mem_read = 1'b1;
          // A ready in the timeout cycle still completes the fetch.
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_inc   = 2'd1;
            state_d  = S_DECODE;
`ifdef CTRL_INTERRUPT_EN
            mask_d   = 1'b0;
`endif
          end else if (cnt_q == TimeoutCnt) begin
            bus_error = 1'b1;
            run_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ALU_src_A = sel_a;
        ALU_src_B = sel_b;
        ALU_op    = sel_op;
        state_d   = done_state;
        case (opcode)
          OP_ADDI:           state_d = S_WB;
          OP_JUMPI: begin
            mem_shift = 1'b1;
            pc_write  = 1'b1;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_CMP:            compare_write = 1'b1;
          OP_SKIP:           pc_inc = should_skip ? 2'd2 : 2'd0;
          default:           illegal_op = 1'b1;
        endcase
      end
      S_MEM: begin
        ALU_src_A = sel_a;
        ALU_src_B = sel_b;
        ALU_op    = sel_op;
        if (opcode == OP_STORE) mem_write = 1'b1;
        else                    mem_read  = 1'b1;
        if (mem_ready) begin
          state_d = (opcode == OP_LOAD) ? S_WB : done_state;
        end else if (cnt_q == TimeoutCnt) begin
          bus_error = 1'b1;
          run_d     = 1'b0;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        ALU_src_A = sel_a;
        ALU_src_B = sel_b;
        ALU_op    = sel_op;
        r_write   = 1'b1;
        state_d   = done_state;
      end
`ifdef CTRL_INTERRUPT_EN
      S_IRQ: begin
        return_address_write = 1'b1;
        r_backup             = 1'b1;
        pc_write             = 1'b1;
        ALU_src_A            = 3'd7;
        mask_d               = 1'b1;
        state_d              = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule
